// File: rtl/cirno_pkg.sv
// Shared types for the cirno CPU control path: sequencer states and
// decoder instruction classes.
package cirno_pkg;

  localparam int CLS_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_IF   = 4'd1,
    ST_DC   = 4'd2,
    ST_CL   = 4'd3,
    ST_OF   = 4'd4,
    ST_EX   = 4'd5,
    ST_RM   = 4'd6,
    ST_WM   = 4'd7,
    ST_WB   = 4'd8,
    ST_BR   = 4'd9,
    ST_DONE = 4'd10
  } state_t;

  typedef enum logic [CLS_W-1:0] {
    CLS_ILL0 = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_BRI  = 3'd2,
    CLS_MOV  = 3'd3,
    CLS_BR   = 3'd4,
    CLS_ST   = 3'd5,
    CLS_LD   = 3'd6,
    CLS_ILL7 = 3'd7
  } inst_class_t;

endpackage

// File: rtl/cirno_phase_timer.sv
// Down-counter that times a multi-cycle phase; expire is high in the
// last cycle of the phase.
module cirno_phase_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic init_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam logic [3:0] LOAD_VAL = 4'(CYCLES - 1);

  logic [3:0] cnt_r;

  // Load on phase entry, then count down to zero while the phase runs.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (run && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == 4'd0);

endmodule

// File: rtl/cirno_sequencer.sv
// Multi-cycle phase sequencer for the cirno CPU. Enables are decoded from
// the next state and registered, so they track the state register exactly.
module cirno_sequencer
  import cirno_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int ALU_CYCLES = 1
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             start,
  input  logic [CLS_W-1:0] inst_class,
  input  logic             halt,
  input  logic             mem_ack,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             opfetch_en,
  output logic             alu_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             reg_w_en,
  output logic             branch_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};

  state_t      state_r;
  state_t      next_s;
  inst_class_t cls_r;
  logic        err_next_s;
  logic        inc_s;
  logic        clr_s;
  logic        load_s;
  logic        expire_s;

  cirno_phase_timer #(.CYCLES(ALU_CYCLES)) u_timer (
    .clk    (clk),
    .init_n (init_n),
    .load   (load_s),
    .run    (state_r == ST_EX),
    .expire (expire_s)
  );

  // Next-state, termination and retirement decode.
  always_comb begin
    next_s     = state_r;
    err_next_s = err;
    inc_s      = 1'b0;
    clr_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_s     = ST_IF;
          err_next_s = 1'b0;
          clr_s      = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      ST_IF: next_s = ST_DC;
      ST_DC: next_s = ST_CL;
      ST_CL: begin
        if (halt) begin
          next_s     = ST_DONE;
          err_next_s = 1'b0;
        end else begin
          case (inst_class_t'(inst_class))
            CLS_ALU, CLS_BR, CLS_ST, CLS_LD: next_s = ST_OF;
            CLS_BRI: next_s = ST_BR;
            CLS_MOV: next_s = ST_WB;
            default: begin
              next_s     = ST_DONE;
              err_next_s = 1'b1;
            end
          endcase
        end
      end
      ST_OF: begin
        case (cls_r)
          CLS_ALU: next_s = ST_EX;
          CLS_BR:  next_s = ST_BR;
          CLS_ST:  next_s = ST_WM;
          CLS_LD:  next_s = ST_RM;
          default: begin
            next_s     = ST_DONE;
            err_next_s = 1'b1;
          end
        endcase
      end
      ST_EX: begin
        if (expire_s) begin
          next_s = ST_WB;
        end else begin
          next_s = ST_EX;
        end
      end
      ST_RM: begin
        if (mem_ack) begin
          next_s = ST_WB;
        end else begin
          next_s = ST_RM;
        end
      end
      ST_WM: begin
        if (mem_ack) begin
          next_s = ST_IF;
          inc_s  = 1'b1;
        end else begin
          next_s = ST_WM;
        end
      end
      ST_WB, ST_BR: begin
        next_s = ST_IF;
        inc_s  = 1'b1;
      end
      default: next_s = ST_IDLE;
    endcase
    load_s = (state_r == ST_OF) && (next_s == ST_EX);
  end

  // State, captured class, retired counter and registered outputs.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_r    <= ST_IDLE;
      cls_r      <= CLS_ILL0;
      retired    <= {CNT_W{1'b0}};
      err        <= 1'b0;
      fetch_en   <= 1'b0;
      decode_en  <= 1'b0;
      opfetch_en <= 1'b0;
      alu_en     <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      reg_w_en   <= 1'b0;
      branch_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r <= next_s;
      cls_r   <= (state_r == ST_CL) ? inst_class_t'(inst_class) : cls_r;
      err     <= err_next_s;
      // Counter saturates rather than wrapping.
      if (clr_s) begin
        retired <= {CNT_W{1'b0}};
      end else if (inc_s && (retired != RET_MAX)) begin
        retired <= retired + CNT_W'(1);
      end else begin
        retired <= retired;
      end
      fetch_en   <= (next_s == ST_IF);
      decode_en  <= (next_s == ST_DC);
      opfetch_en <= (next_s == ST_OF);
      alu_en     <= (next_s == ST_EX);
      mem_r_en   <= (next_s == ST_RM);
      mem_w_en   <= (next_s == ST_WM);
      reg_w_en   <= (next_s == ST_WB);
      branch_en  <= (next_s == ST_BR);
      busy       <= (next_s != ST_IDLE) && (next_s != ST_DONE);
      done       <= (next_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_cirno_sequencer.sv
// Randomised bench for cirno_sequencer: two instances (ALU_CYCLES=3/CNT_W=16
// and ALU_CYCLES=1/CNT_W=2) checked against a per-instruction phase-list model.
module tb_cirno_sequencer;

  localparam logic [7:0] P_F = 8'h01;
  localparam logic [7:0] P_D = 8'h02;
  localparam logic [7:0] P_N = 8'h00;
  localparam logic [7:0] P_O = 8'h04;
  localparam logic [7:0] P_A = 8'h08;
  localparam logic [7:0] P_R = 8'h10;
  localparam logic [7:0] P_W = 8'h20;
  localparam logic [7:0] P_G = 8'h40;
  localparam logic [7:0] P_B = 8'h80;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        start_v [2];
  logic [2:0]  cls_v   [2];
  logic        halt_v  [2];
  logic        ack_v   [2];
  logic [7:0]  en0, en1;
  logic        busy0, busy1, done0, done1, err0, err1;
  logic [15:0] ret0;
  logic [1:0]  ret1;

  int n_checks = 0;
  int n_fail   = 0;
  int ret_m [2];
  bit err_m [2];
  int alu_m [2] = '{3, 1};
  int max_m [2] = '{65535, 3};

  always #5 clk = ~clk;

  cirno_sequencer #(.CNT_W(16), .ALU_CYCLES(3)) dut0 (
    .clk(clk), .init_n(init_n), .start(start_v[0]), .inst_class(cls_v[0]),
    .halt(halt_v[0]), .mem_ack(ack_v[0]),
    .fetch_en(en0[0]), .decode_en(en0[1]), .opfetch_en(en0[2]), .alu_en(en0[3]),
    .mem_r_en(en0[4]), .mem_w_en(en0[5]), .reg_w_en(en0[6]), .branch_en(en0[7]),
    .busy(busy0), .done(done0), .err(err0), .retired(ret0)
  );

  cirno_sequencer #(.CNT_W(2), .ALU_CYCLES(1)) dut1 (
    .clk(clk), .init_n(init_n), .start(start_v[1]), .inst_class(cls_v[1]),
    .halt(halt_v[1]), .mem_ack(ack_v[1]),
    .fetch_en(en1[0]), .decode_en(en1[1]), .opfetch_en(en1[2]), .alu_en(en1[3]),
    .mem_r_en(en1[4]), .mem_w_en(en1[5]), .reg_w_en(en1[6]), .branch_en(en1[7]),
    .busy(busy1), .done(done1), .err(err1), .retired(ret1)
  );

  function automatic logic [7:0] en_of(input int d);
    if (d == 0) return en0;
    else return en1;
  endfunction
  function automatic logic busy_of(input int d);
    if (d == 0) return busy0;
    else return busy1;
  endfunction
  function automatic logic done_of(input int d);
    if (d == 0) return done0;
    else return done1;
  endfunction
  function automatic logic err_of(input int d);
    if (d == 0) return err0;
    else return err1;
  endfunction
  function automatic logic [15:0] ret_of(input int d);
    if (d == 0) return ret0;
    else return {14'd0, ret1};
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; cls_v[d] = 3'd0; halt_v[d] = 1'b0; ack_v[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    init_n = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({en_of(d), busy_of(d), done_of(d), err_of(d)} !== 11'd0 || ret_of(d) !== 16'd0) begin
        n_fail++;
        $display("FAIL reset d%0d: en=%h busy=%b done=%b err=%b ret=%0d, required all 0",
                 d, en_of(d), busy_of(d), done_of(d), err_of(d), ret_of(d));
      end
      ret_m[d] = 0; err_m[d] = 1'b0;
    end
    @(negedge clk); init_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (busy_of(d) !== 1'b0 || done_of(d) !== 1'b0 || en_of(d) !== 8'd0) begin
        n_fail++;
        $display("FAIL idle_after_reset d%0d: busy=%b done=%b en=%h, required 0/0/00",
                 d, busy_of(d), done_of(d), en_of(d));
      end
    end
  endtask

  // Pulse start from IDLE or DONE; counter and err must clear.
  task automatic do_start(input int d);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    ret_m[d] = 0; err_m[d] = 1'b0;
    n_checks++;
    if (ret_of(d) !== 16'd0 || err_of(d) !== 1'b0 || done_of(d) !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clear d%0d: ret=%0d err=%b done=%b, required 0/0/0",
               d, ret_of(d), err_of(d), done_of(d));
    end
  endtask

  // Runs one instruction from its IF cycle and checks every cycle's enables.
  task automatic run_inst(input int d, input int cls, input bit hlt, input int dly,
                          input int stop_after);
    logic [7:0] ph [$];
    int mem_i;
    bit ends;
    ph = '{P_F, P_D, P_N};
    ends = !(hlt || cls == 0 || cls == 7);
    if (ends) begin
      case (cls)
        1: begin ph.push_back(P_O); repeat (alu_m[d]) ph.push_back(P_A); ph.push_back(P_G); end
        2: ph.push_back(P_B);
        3: ph.push_back(P_G);
        4: begin ph.push_back(P_O); ph.push_back(P_B); end
        5: begin ph.push_back(P_O); repeat (dly + 1) ph.push_back(P_W); end
        6: begin ph.push_back(P_O); repeat (dly + 1) ph.push_back(P_R); ph.push_back(P_G); end
        default: ;
      endcase
    end
    mem_i = 0;
    for (int i = 0; i < ph.size(); i++) begin
      if (i == stop_after) return;
      n_checks++;
      if (en_of(d) !== ph[i] || busy_of(d) !== 1'b1 || done_of(d) !== 1'b0) begin
        n_fail++;
        $display("FAIL phase d%0d cls%0d step%0d: en=%h busy=%b done=%b, required en=%h busy=1 done=0",
                 d, cls, i, en_of(d), busy_of(d), done_of(d), ph[i]);
      end
      start_v[d] = ($urandom_range(0, 3) == 0);
      if (ph[i] == P_N) begin
        cls_v[d] = 3'(cls); halt_v[d] = hlt;
      end else begin
        cls_v[d] = 3'($urandom); halt_v[d] = 1'($urandom);
      end
      if (ph[i] == P_R || ph[i] == P_W) begin
        ack_v[d] = (mem_i == dly); mem_i++;
      end else if (ph[i] == P_O && dly == 0) begin
        ack_v[d] = 1'b1;
      end else begin
        ack_v[d] = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start_v[d] = 1'b0; halt_v[d] = 1'b0; ack_v[d] = 1'b0;
    if (ends) begin
      if (ret_m[d] < max_m[d]) ret_m[d]++;
    end else begin
      err_m[d] = !hlt;
    end
    n_checks++;
    if (ret_of(d) !== 16'(ret_m[d])) begin
      n_fail++;
      $display("FAIL retired d%0d: got %0d, required %0d", d, ret_of(d), ret_m[d]);
    end
    if (!ends) begin
      n_checks++;
      if (done_of(d) !== 1'b1 || busy_of(d) !== 1'b0 || err_of(d) !== err_m[d] || en_of(d) !== 8'd0) begin
        n_fail++;
        $display("FAIL done_state d%0d: done=%b busy=%b err=%b en=%h, required 1/0/%b/00",
                 d, done_of(d), busy_of(d), err_of(d), en_of(d), err_m[d]);
      end
    end
  endtask

  task automatic test_alu1_then_halt();
    do_start(1);
    run_inst(1, 1, 1'b0, 0, -1);
    run_inst(1, $urandom_range(0, 7), 1'b1, 0, -1);
  endtask

  task automatic test_alu3_ld_st();
    do_start(0);
    run_inst(0, 1, 1'b0, 0, -1);
    run_inst(0, 6, 1'b0, 2, -1);
    run_inst(0, 5, 1'b0, 0, -1);
    run_inst(0, 3, 1'b0, 0, -1);
  endtask

  task automatic test_illegal_and_restart();
    run_inst(0, 7, 1'b0, 0, -1);
    for (int k = 0; k < 3; k++) begin
      cls_v[0] = 3'($urandom); halt_v[0] = 1'($urandom); ack_v[0] = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (done0 !== 1'b1 || err0 !== 1'b1 || en0 !== 8'd0 || ret0 !== 16'(ret_m[0])) begin
        n_fail++;
        $display("FAIL done_hold: done=%b err=%b en=%h ret=%0d, required 1/1/00/%0d",
                 done0, err0, en0, ret0, ret_m[0]);
      end
    end
    do_start(0);
    run_inst(0, 2, 1'b0, 0, -1);
    run_inst(0, 0, 1'b0, 0, -1);
  endtask

  task automatic test_random();
    do_start(0);
    for (int k = 0; k < 40; k++) begin
      run_inst(0, $urandom_range(1, 6), 1'b0, $urandom_range(0, 3), -1);
    end
    run_inst(0, 7 * $urandom_range(0, 1), ($urandom_range(0, 1) == 1), 0, -1);
  endtask

  task automatic test_saturate();
    do_start(1);
    for (int k = 0; k < 5; k++) begin
      run_inst(1, $urandom_range(1, 6), 1'b0, $urandom_range(0, 2), -1);
    end
    run_inst(1, 3, 1'b1, 0, -1);
  endtask

  task automatic test_reset_mid_rm();
    do_start(0);
    run_inst(0, 3, 1'b0, 0, -1);
    run_inst(0, 6, 1'b0, 6, 5);
    #2 init_n = 1'b0;
    #1;
    n_checks++;
    if ({en0, busy0, done0, err0} !== 11'd0 || ret0 !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: en=%h busy=%b done=%b err=%b ret=%0d, required all 0",
               en0, busy0, done0, err0, ret0);
    end
    idle_inputs();
    @(negedge clk); init_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      ret_m[d] = 0; err_m[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu1_then_halt();
    test_alu3_ld_st();
    test_illegal_and_restart();
    test_random();
    test_saturate();
    test_reset_mid_rm();
    test_alu3_ld_st();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
